// File: rtl/demux_rr_dispatch_x4.sv
// Round-robin dispatcher: steers each accepted input word to one of four
// flow-controlled output channels, skipping busy or disabled channels.
module demux_rr_dispatch_x4 #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] y,
  input  logic                 y_valid,
  output logic                 y_ready,
  input  logic [3:0]           en,
  output logic [BUS_WIDTH-1:0] a,
  output logic [BUS_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0] c,
  output logic [BUS_WIDTH-1:0] d,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [1:0]           sel,
  output logic [15:0]          count
);

  logic [BUS_WIDTH-1:0] data_q [4];
  logic [BUS_WIDTH-1:0] data_d [4];
  logic [3:0]           valid_q, valid_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           sel_q, sel_d;
  logic [15:0]          count_q, count_d;

  logic [3:0]           eligible_s;
  logic [1:0]           grant_s;
  logic                 accept_s;

  assign eligible_s = en & (~valid_q | out_ready);
  assign y_ready    = rst_n & (|eligible_s);
  assign accept_s   = y_valid & y_ready;

  // Grant search: first eligible channel at or above ptr, wrapping 3 -> 0.
  always_comb begin : grant_search
    logic       found;
    logic [1:0] idx;
    grant_s = ptr_q;
    found   = 1'b0;
    idx     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && eligible_s[idx]) begin
        grant_s = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  end

  // Next-state for channel registers, pointer, grant index and word counter.
  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    count_d = count_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      if (accept_s && (grant_s == 2'(i))) begin
        data_d[i]  = y;
        valid_d[i] = 1'b1;
      end else if (valid_q[i] && out_ready[i]) begin
        data_d[i]  = {BUS_WIDTH{1'b0}};
        valid_d[i] = 1'b0;
      end else begin
        data_d[i]  = data_q[i];
        valid_d[i] = valid_q[i];
      end
    end
    if (accept_s) begin
      ptr_d   = grant_s + 2'd1;
      sel_d   = grant_s;
      count_d = count_q + 16'd1;
    end else begin
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      count_d = count_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= {BUS_WIDTH{1'b0}};
      end
      valid_q <= 4'b0000;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      count_q <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      count_q <= count_d;
    end
  end

  assign a         = data_q[0];
  assign b         = data_q[1];
  assign c         = data_q[2];
  assign d         = data_q[3];
  assign out_valid = valid_q;
  assign sel       = sel_q;
  assign count     = count_q;

endmodule

// File: tb/tb_demux_rr_dispatch_x4.sv
// Directed bench for demux_rr_dispatch_x4 with hand-computed expectations.
module tb_demux_rr_dispatch_x4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  y;
  logic        y_valid;
  logic        y_ready;
  logic [3:0]  en;
  logic [7:0]  a, b, c, d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  sel;
  logic [15:0] count;

  int vectors;
  int miscompares;

  demux_rr_dispatch_x4 #(.BUS_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .en(en), .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid),
    .out_ready(out_ready), .sel(sel), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chan(input int idx);
    case (idx)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  initial begin
    int exp_ch [4];
    vectors     = 0;
    miscompares = 0;

    // Reset with a word offered.
    rst_n = 1'b0; y = 8'hEE; y_valid = 1'b1; en = 4'hF; out_ready = 4'hF;
    #1;
    check("reset_y_ready_pre", 32'(y_ready), 32'd0);
    tick();
    tick();
    check("reset_y_ready", 32'(y_ready), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", {a, b, c, d}, 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_count", 32'(count), 32'd0);

    // Round-robin order with everything free.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      y = 8'h10 + 8'(i);
      #1;
      check("rr_y_ready", 32'(y_ready), 32'd1);
      tick();
      check("rr_sel", 32'(sel), 32'(i % 4));
      check("rr_data", 32'(chan(i % 4)), 32'(8'h10 + 8'(i)));
      check("rr_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
    end
    check("rr_count", 32'(count), 32'd8);
    y_valid = 1'b0;
    tick();
    check("rr_drained", 32'(out_valid), 32'd0);

    // Skip a stalled channel b.
    out_ready = 4'b1101; y_valid = 1'b1;
    y = 8'hA0; tick();
    check("skip_a", 32'(a), 32'hA0);
    y = 8'hA1; tick();
    check("skip_b", 32'(b), 32'hA1);
    y = 8'hA2; tick();
    check("skip_c", 32'(c), 32'hA2);
    check("skip_b_hold1", 32'(b), 32'hA1);
    y = 8'hA3; tick();
    check("skip_d", 32'(d), 32'hA3);
    y = 8'hA4; tick();
    check("skip_sel_a", 32'(sel), 32'd0);
    check("skip_a2", 32'(a), 32'hA4);
    check("skip_b_hold2", 32'(b), 32'hA1);
    check("skip_count", 32'(count), 32'd13);
    y_valid = 1'b0; tick();
    check("skip_b_hold3", 32'(b), 32'hA1);
    check("skip_valid", 32'(out_valid), 32'b0010);
    out_ready = 4'hF; tick();
    check("skip_b_clear", 32'(b), 32'd0);
    check("skip_all_empty", 32'(out_valid), 32'd0);

    // All channels blocked; ptr is at b.
    out_ready = 4'b0000; y_valid = 1'b1;
    exp_ch = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      y = 8'hB0 + 8'(i);
      tick();
      check("blk_sel", 32'(sel), 32'(exp_ch[i]));
      check("blk_data", 32'(chan(exp_ch[i])), 32'(8'hB0 + 8'(i)));
    end
    check("blk_y_ready", 32'(y_ready), 32'd0);
    check("blk_count", 32'(count), 32'd17);
    y = 8'hB4; tick();
    check("blk_count_hold", 32'(count), 32'd17);
    check("blk_a_hold", 32'(a), 32'hB3);
    out_ready = 4'b0100; #1;
    check("blk_y_ready_c", 32'(y_ready), 32'd1);
    tick();
    check("blk_sel_c", 32'(sel), 32'd2);
    check("blk_c_data", 32'(c), 32'hB4);
    check("blk_valid", 32'(out_valid), 32'hF);
    check("blk_count2", 32'(count), 32'd18);

    // Enable mask with a stalled word in channel a.
    y_valid = 1'b0; out_ready = 4'hF; tick();
    check("en_empty", 32'(out_valid), 32'd0);
    en = 4'b0001; out_ready = 4'b0000; y = 8'h55; y_valid = 1'b1; tick();
    check("en_a_load", 32'(a), 32'h55);
    en = 4'b1010; out_ready = 4'b1110;
    exp_ch = '{1, 3, 1, 0};
    for (int i = 0; i < 3; i++) begin
      y = 8'hC0 + 8'(i);
      tick();
      check("en_sel", 32'(sel), 32'(exp_ch[i]));
      check("en_data", 32'(chan(exp_ch[i])), 32'(8'hC0 + 8'(i)));
      check("en_a_hold", 32'(a), 32'h55);
    end
    check("en_count", 32'(count), 32'd22);
    en = 4'b0000; #1;
    check("en_zero_ready", 32'(y_ready), 32'd0);
    y_valid = 1'b0; out_ready = 4'hF; tick();
    check("en_a_drain", 32'(a), 32'd0);
    check("en_all_empty", 32'(out_valid), 32'd0);

    // Counter wrap.
    en = 4'hF; y_valid = 1'b1;
    for (int i = 0; i < 65513; i++) begin
      y = 8'(i);
      tick();
    end
    check("wrap_ffff", 32'(count), 32'hFFFF);
    tick();
    check("wrap_zero", 32'(count), 32'd0);

    // Mid-run reset while c holds data.
    en = 4'b0100; out_ready = 4'b1011; y = 8'h77; tick();
    check("mrst_c_data", 32'(c), 32'h77);
    check("mrst_c_valid", 32'(out_valid), 32'b0100);
    rst_n = 1'b0; #1;
    check("mrst_y_ready", 32'(y_ready), 32'd0);
    tick();
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_c_clear", 32'(c), 32'd0);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_sel", 32'(sel), 32'd0);
    rst_n = 1'b1; en = 4'hF; out_ready = 4'hF; y = 8'h88; tick();
    check("mrst_ptr_a", 32'(a), 32'h88);
    check("mrst_sel_a", 32'(sel), 32'd0);
    check("mrst_count1", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
